spi_slave_core: RTL and testbench

//  SPI target-side shift engine, the counterpart of the SPI master core: answers a remote master's SCK/CSn.

---
 rtl/spi_slave_core.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI target shift engine: oversamples SCK/CSn/MOSI, shifts MISO from a TX holding register, returns RX words on valid/ready.
// Optional LSB-first support is enabled by defining SPI_SLV_LSB_EN (adds the lsb_i port).
module spi_slave_core #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cpol_i,
   input  logic                  cpha_i,
   input  logic [1:0]            dtb_i,
`ifdef SPI_SLV_LSB_EN
   input  logic                  lsb_i,
`endif
   input  logic                  clr_i,
   output logic                  busy_o,
   output logic                  underrun_o,
   output logic                  overrun_o,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   input  logic                  spi_sck_i,
   input  logic                  spi_csn_i,
   input  logic                  spi_mosi_i,
   output logic                  spi_miso_o,
   output logic                  spi_miso_oe_o
);
   localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
   localparam int unsigned IW = $clog2(DATA_WIDTH);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
   logic                   sck_q, csn_q;
   logic                   cpol_q, cpha_q;
   logic [1:0]             dtb_q;
   logic [DATA_WIDTH-1:0]  hold_q, tx_sr, rx_sr;
   logic [CW-1:0]          bit_cnt;

`ifdef SPI_SLV_LSB_EN
   logic lsb_q;
   logic lsb_in;
   assign lsb_in = lsb_i;
`else
   localparam logic lsb_q  = 1'b0;
   localparam logic lsb_in = 1'b0;
`endif

   // Bit position of the cnt-th bit of a word, given order and word length
   function automatic logic [IW-1:0] bit_idx(input logic lsb, input logic [1:0] dtb,
                                             input logic [CW-1:0] cnt);
      logic [CW-1:0] len;
      len     = CW'({dtb, 3'b000}) + CW'(8);
      bit_idx = lsb ? IW'(cnt) : IW'(len - CW'(1) - cnt);
   endfunction

   logic sck_s, csn_s, mosi_s;
   logic sck_rise, sck_fall, lead, trail, sample_edge, shift_edge, csn_fall, csn_rise;
   logic [CW-1:0]         len_q, cnt_inc;
   logic                  word_done;
   logic [DATA_WIDTH-1:0] load_word, rx_next;

   assign sck_s       = sck_sync[SYNC_STAGES-1];
   assign csn_s       = csn_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign sck_rise    = sck_s & ~sck_q;
   assign sck_fall    = ~sck_s & sck_q;
   assign csn_fall    = ~csn_s & csn_q;
   assign csn_rise    = csn_s & ~csn_q;
   assign lead        = cpol_q ? sck_fall : sck_rise;
   assign trail       = cpol_q ? sck_rise : sck_fall;
   assign sample_edge = cpha_q ? trail : lead;
   assign shift_edge  = cpha_q ? lead : trail;
   assign len_q       = CW'({dtb_q, 3'b000}) + CW'(8);
   assign cnt_inc     = bit_cnt + CW'(1);
   assign word_done   = sample_edge && (cnt_inc == len_q);
   assign load_word   = tx_ready_o ? '0 : hold_q;
   assign rx_next     = lsb_q ? ((rx_sr >> 1) | (DATA_WIDTH'(mosi_s) << (len_q - CW'(1))))
                              : {rx_sr[DATA_WIDTH-2:0], mosi_s};
   assign spi_miso_oe_o = busy_o;

   // Pad synchronizers and previous-value registers for edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_sync  <= '0;
         csn_sync  <= '1;
         mosi_sync <= '0;
         sck_q     <= 1'b0;
         csn_q     <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
         csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         sck_q     <= sck_s;
         csn_q     <= csn_s;
      end
   end

   // Frame FSM, shift registers and handshakes; later assignments take priority
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         busy_o     <= 1'b0;
         underrun_o <= 1'b0;
         overrun_o  <= 1'b0;
         rx_valid_o <= 1'b0;
         rx_data_o  <= '0;
         spi_miso_o <= 1'b0;
         tx_ready_o <= 1'b1;
         hold_q     <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         bit_cnt    <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         dtb_q      <= '0;
`ifdef SPI_SLV_LSB_EN
         lsb_q      <= 1'b0;
`endif
      end else begin
         if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
         if (tx_valid_i && tx_ready_o) begin
            hold_q     <= tx_data_i;
            tx_ready_o <= 1'b0;
         end
         if (clr_i) begin
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (csn_fall) begin
                  state   <= ACTIVE;
                  busy_o  <= 1'b1;
                  cpol_q  <= cpol_i;
                  cpha_q  <= cpha_i;
                  dtb_q   <= dtb_i;
`ifdef SPI_SLV_LSB_EN
                  lsb_q   <= lsb_i;
`endif
                  tx_sr   <= load_word;
                  bit_cnt <= '0;
                  rx_sr   <= '0;
                  if (tx_ready_o) underrun_o <= 1'b1;
                  else            tx_ready_o <= 1'b1;
                  if (!cpha_i) spi_miso_o <= load_word[bit_idx(lsb_in, dtb_i, '0)];
               end
            end
            ACTIVE: begin
               if (csn_rise) begin
                  state      <= IDLE;
                  busy_o     <= 1'b0;
                  spi_miso_o <= 1'b0;
               end else if (word_done) begin
                  if (rx_valid_o && !rx_ready_i) begin
                     overrun_o <= 1'b1;
                  end else begin
                     rx_data_o  <= rx_next;
                     rx_valid_o <= 1'b1;
                  end
                  tx_sr   <= load_word;
                  bit_cnt <= '0;
                  rx_sr   <= '0;
                  if (tx_ready_o) underrun_o <= 1'b1;
                  else            tx_ready_o <= 1'b1;
                  if (!cpha_q) spi_miso_o <= load_word[bit_idx(lsb_q, dtb_q, '0)];
               end else if (sample_edge) begin
                  rx_sr   <= rx_next;
                  bit_cnt <= cnt_inc;
               end else if (shift_edge) begin
                  spi_miso_o <= tx_sr[bit_idx(lsb_q, dtb_q, bit_cnt)];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: bit-banged SPI master, TX feeder, RX scoreboard monitor.
module tb_spi_slave_core;
   logic        clk = 1'b0;
   logic        rst, cpol, cpha, clr, lsb_mode;
   logic [1:0]  dtb;
   logic        tx_valid, rx_ready;
   logic [31:0] tx_data;
   logic        sck, csn, mosi;
   logic        busy_o, underrun_o, overrun_o, tx_ready_o, rx_valid_o;
   logic [31:0] rx_data_o;
   logic        spi_miso_o, spi_miso_oe_o;

   int tests = 0;
   int fails = 0;

   logic [31:0] tx_q[$];
   logic [31:0] rx_exp[$];
   logic [31:0] m_tx[4];
   logic [31:0] m_rx[4];

   always #5 clk = ~clk;

   spi_slave_core dut (
      .clk_i(clk), .rst_i(rst), .cpol_i(cpol), .cpha_i(cpha), .dtb_i(dtb),
`ifdef SPI_SLV_LSB_EN
      .lsb_i(lsb_mode),
`endif
      .clr_i(clr), .busy_o(busy_o), .underrun_o(underrun_o), .overrun_o(overrun_o),
      .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data),
      .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready), .rx_data_o(rx_data_o),
      .spi_sck_i(sck), .spi_csn_i(csn), .spi_mosi_i(mosi),
      .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic half();
      repeat (4) tick();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
   endtask

   // Offer one TX word and wait (bounded) until the DUT has taken it
   task automatic send_tx(input logic [31:0] w);
      bit ok = 1'b0;
      tx_q.push_back(w);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx_q.size() == 0 && !tx_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("tx_accept_timeout", 32'd0, 32'd1);
   endtask

   // Bit-banged master at clk/8; stop_at<0 runs all bits, hold_csn leaves CSn low at the end
   task automatic spi_frame(input bit pol, input bit pha, input logic [1:0] wl, input int nw,
                            input int stop_at, input bit hold_csn);
      int len, cnt;
      bit b, got, stop;
      len  = 8 * (int'(wl) + 1);
      cpol = pol; cpha = pha; dtb = wl;
      sck  = pol;
      half();
      csn  = 1'b0;
      cnt  = 0;
      stop = 1'b0;
      if (pha) half();
      for (int w = 0; w < nw && !stop; w++) begin
         m_rx[w] = '0;
         for (int i = 0; i < len; i++) begin
            if (cnt == stop_at) begin
               stop = 1'b1;
               break;
            end
            b = lsb_mode ? m_tx[w][i] : m_tx[w][len-1-i];
            if (!pha) begin
               mosi = b;
               half();
               got = spi_miso_o;
               sck = ~pol;
               half();
               sck = pol;
            end else begin
               sck  = ~pol;
               mosi = b;
               half();
               got = spi_miso_o;
               sck = pol;
               half();
            end
            if (lsb_mode) m_rx[w][i] = got;
            else          m_rx[w][len-1-i] = got;
            cnt++;
         end
      end
      half();
      if (!hold_csn) begin
         csn = 1'b1;
         half();
         half();
      end
   endtask

   // TX feeder: presents the head of tx_q and pops it once the handshake has happened
   initial begin
      bit acc;
      tx_valid = 1'b0;
      tx_data  = '0;
      forever begin
         @(negedge clk);
         acc = tx_valid && tx_ready_o;
         @(posedge clk);
         #1;
         if (acc) void'(tx_q.pop_front());
         tx_valid = (tx_q.size() > 0);
         tx_data  = tx_valid ? tx_q[0] : '0;
      end
   end

   // RX monitor: every accepted word must match the oldest expected word
   initial begin
      logic [31:0] exp;
      forever begin
         @(negedge clk);
         if (!rst && rx_valid_o && rx_ready) begin
            tests++;
            if (rx_exp.size() == 0) begin
               fails++;
               $display("FAIL rx_unexpected: got %h, required no word", rx_data_o);
            end else begin
               exp = rx_exp.pop_front();
               if (rx_data_o !== exp) begin
                  fails++;
                  $display("FAIL rx_word: got %h, required %h", rx_data_o, exp);
               end
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"},     32'(busy_o),        32'd0);
      check({tag, "_oe"},       32'(spi_miso_oe_o), 32'd0);
      check({tag, "_miso"},     32'(spi_miso_o),    32'd0);
      check({tag, "_txready"},  32'(tx_ready_o),    32'd1);
      check({tag, "_rxvalid"},  32'(rx_valid_o),    32'd0);
      check({tag, "_rxdata"},   rx_data_o,          32'd0);
      check({tag, "_underrun"}, 32'(underrun_o),    32'd0);
      check({tag, "_overrun"},  32'(overrun_o),     32'd0);
   endtask

   initial begin
      bit          pol, pha;
      logic [1:0]  wl;
      int          nw, len;
      logic [31:0] mask;
      logic [31:0] txw[4];
      bit          ok;

      rst = 1'b1; cpol = 1'b0; cpha = 1'b0; dtb = 2'd0; clr = 1'b0; lsb_mode = 1'b0;
      rx_ready = 1'b1; sck = 1'b0; csn = 1'b1; mosi = 1'b0;
      repeat (4) tick();
      check_reset_state("reset");
      rst = 1'b0;
      repeat (4) tick();

      // Mode 0, 8-bit
      send_tx(32'hA5);
      m_tx[0] = 32'h3C;
      rx_exp.push_back(32'h3C);
      spi_frame(1'b0, 1'b0, 2'd0, 1, -1, 1'b0);
      check("m0_miso", m_rx[0], 32'hA5);
      check("m0_idle_busy", 32'(busy_o), 32'd0);

      // Mode 3, 32-bit
      send_tx(32'hDEADBEEF);
      m_tx[0] = 32'h12345678;
      rx_exp.push_back(32'h12345678);
      spi_frame(1'b1, 1'b1, 2'd3, 1, -1, 1'b0);
      check("m3_miso", m_rx[0], 32'hDEADBEEF);

      // Two 16-bit words in one frame, only the first TX word supplied
      pulse_clr();
      check("b2b_underrun_clr", 32'(underrun_o), 32'd0);
      send_tx(32'hBEEF);
      m_tx[0] = 32'h1234; m_tx[1] = 32'hABCD;
      rx_exp.push_back(32'h1234);
      rx_exp.push_back(32'hABCD);
      spi_frame(1'b0, 1'b0, 2'd1, 2, -1, 1'b0);
      check("b2b_miso0", m_rx[0], 32'hBEEF);
      check("b2b_miso1", m_rx[1], 32'h0000);
      check("b2b_underrun", 32'(underrun_o), 32'd1);
      pulse_clr();
      check("b2b_underrun_cleared", 32'(underrun_o), 32'd0);

      // Overrun: consumer stalled across two 8-bit words
      rx_ready = 1'b0;
      m_tx[0] = 32'h11; m_tx[1] = 32'h22;
      rx_exp.push_back(32'h11);
      spi_frame(1'b0, 1'b0, 2'd0, 2, -1, 1'b0);
      check("ovr_flag", 32'(overrun_o), 32'd1);
      check("ovr_data", rx_data_o, 32'h11);
      check("ovr_valid", 32'(rx_valid_o), 32'd1);
      rx_ready = 1'b1;
      repeat (3) tick();
      check("ovr_valid_drop", 32'(rx_valid_o), 32'd0);
      pulse_clr();
      check("ovr_cleared", 32'(overrun_o), 32'd0);

      // Frame aborted after 5 bits, then a clean frame
      m_tx[0] = 32'hFF;
      spi_frame(1'b0, 1'b0, 2'd0, 1, 5, 1'b0);
      check("abort_valid", 32'(rx_valid_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      m_tx[0] = 32'h5A;
      rx_exp.push_back(32'h5A);
      spi_frame(1'b0, 1'b0, 2'd0, 1, -1, 1'b0);

      // Randomized frames: mode, word length and word count per frame
      for (int f = 0; f < 12; f++) begin
         pol  = 1'($urandom_range(0, 1));
         pha  = 1'($urandom_range(0, 1));
         wl   = 2'($urandom_range(0, 3));
         nw   = $urandom_range(1, 3);
         len  = 8 * (int'(wl) + 1);
         mask = 32'((64'h1 << len) - 64'h1);
         for (int w = 0; w < nw; w++) begin
            m_tx[w] = $urandom & mask;
            txw[w]  = $urandom & mask;
            tx_q.push_back(txw[w]);
            rx_exp.push_back(m_tx[w]);
         end
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_q.size() < nw) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) check($sformatf("rand%0d_tx_timeout", f), 32'd0, 32'd1);
         spi_frame(pol, pha, wl, nw, -1, 1'b0);
         for (int w = 0; w < nw; w++)
            check($sformatf("rand%0d_miso%0d", f, w), m_rx[w], txw[w]);
      end

`ifdef SPI_SLV_LSB_EN
      // LSB-first, mode 1, 8-bit
      lsb_mode = 1'b1;
      send_tx(32'h6C);
      m_tx[0] = 32'h81;
      rx_exp.push_back(32'h81);
      spi_frame(1'b0, 1'b1, 2'd0, 1, -1, 1'b0);
      check("lsb_miso", m_rx[0], 32'h6C);
      lsb_mode = 1'b0;
`endif

      // Drain outstanding RX expectations
      for (int i = 0; i < 50 && rx_exp.size() > 0; i++) tick();
      check("rx_drained", 32'(rx_exp.size()), 32'd0);

      // Reset in the middle of a frame
      pulse_clr();
      m_tx[0] = 32'hC3;
      spi_frame(1'b0, 1'b0, 2'd0, 1, 4, 1'b1);
      check("midrst_busy_before", 32'(busy_o), 32'd1);
      rst = 1'b1;
      tick();
      tick();
      check_reset_state("midrst");
      csn = 1'b1;
      sck = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      repeat (6) tick();
      check("midrst_idle", 32'(busy_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
